// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter and sequencer for a single-port 32-bit block RAM
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [31:0]       i_req_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] i_rsp_rdata,
    output logic              i_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [31:0]       d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_rdata,
    output logic              d_rsp_err,
    output logic              ena,
    output logic [0:0]        wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
    state_t state, state_nx;
    logic pref_i, pref_i_nx, own_i, own_i_nx, err_q, err_nx;
    logic [DATA_W-1:0] rdata_q, rdata_nx;
    logic [1:0] cnt, cnt_nx;
    logic gnt_i, gnt_d, accept, bad, we, hs;
    logic [31:0] addr;
    always_comb begin
        gnt_i = i_req_valid && (!d_req_valid || pref_i);
        gnt_d = d_req_valid && !gnt_i;
        // reset gating keeps the combinational handshake and RAM strobes low while rsta_n is low
        accept = rsta_n && state == IDLE && (gnt_i || gnt_d);
        addr = gnt_i ? i_req_addr : d_req_addr;
        we = gnt_d && d_req_we;
        bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
        i_req_ready = accept && gnt_i;
        d_req_ready = accept && gnt_d;
        ena = accept && !bad;
        wea = ena && we;
        addra = ena ? addr[ADDR_W+1:2] : '0;
        dina = wea ? d_req_wdata : '0;
        i_rsp_valid = state == RESP && own_i;
        d_rsp_valid = state == RESP && !own_i;
        i_rsp_rdata = i_rsp_valid ? rdata_q : '0;
        d_rsp_rdata = d_rsp_valid ? rdata_q : '0;
        i_rsp_err = i_rsp_valid && err_q;
        d_rsp_err = d_rsp_valid && err_q;
        hs = (i_rsp_valid && i_rsp_ready) || (d_rsp_valid && d_rsp_ready);
        state_nx = state;
        pref_i_nx = pref_i;
        own_i_nx = own_i;
        err_nx = err_q;
        rdata_nx = rdata_q;
        cnt_nx = cnt;
        if (accept) begin
            own_i_nx = gnt_i;
            pref_i_nx = gnt_d;
            err_nx = bad;
            rdata_nx = '0;
            cnt_nx = 2'd1;
            state_nx = (bad || we) ? RESP : RD_WAIT;
        end else if (state == RD_WAIT) begin
            if (cnt == 2'(RD_LAT)) begin
                rdata_nx = douta;
                state_nx = RESP;
            end else begin
                cnt_nx = cnt + 2'd1;
            end
        end else if (state == RESP && hs) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state <= IDLE;
            pref_i <= 1'b0;
            own_i <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            pref_i <= pref_i_nx;
            own_i <= own_i_nx;
            err_q <= err_nx;
            rdata_q <= rdata_nx;
            cnt <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a behavioural read-first block RAM
module tb_mem_arbiter;
    logic        clka = 1'b0;
    logic        rsta_n = 1'b0;
    logic        i_req_valid = 1'b0, i_req_ready, i_rsp_valid, i_rsp_ready = 1'b0, i_rsp_err;
    logic [31:0] i_req_addr = '0, i_rsp_rdata;
    logic        d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0, d_rsp_valid, d_rsp_ready = 1'b0, d_rsp_err;
    logic [31:0] d_req_addr = '0, d_req_wdata = '0, d_rsp_rdata;
    logic        ena;
    logic [0:0]  wea;
    logic [15:0] addra;
    logic [31:0] dina, douta = '0;
    logic [31:0] mem [0:65535];
    int vectors = 0, miscompares = 0;
    logic any_out;

    mem_arbiter dut (
        .clka(clka), .rsta_n(rsta_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
    );

    always #5 clka = ~clka;

    always @(posedge clka) begin
        if (ena) begin
            if (wea[0]) mem[addra] <= dina;
            douta <= mem[addra];
        end
    end

    assign any_out = i_req_ready | d_req_ready | i_rsp_valid | d_rsp_valid | i_rsp_err | d_rsp_err
                   | ena | wea[0] | (|addra) | (|dina) | (|i_rsp_rdata) | (|d_rsp_rdata);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clka);
        #1;
    endtask

    task automatic mid;
        @(negedge clka);
    endtask

    initial begin
        int ng;
        int gseq [4];
        mem[0] = 32'h01234567;
        mem[1] = 32'hDEADBEEF;
        i_req_valid = 1'b1;
        i_req_addr = 32'h4;
        #12;
        check("rst_outs", 32'(any_out), 32'd0);
        check("rst_iready", 32'(i_req_ready), 32'd0);
        i_req_valid = 1'b0;
        tick;
        rsta_n = 1'b1;
        i_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        // fetch read of word 1
        i_req_valid = 1'b1;
        i_req_addr = 32'h4;
        mid;
        check("rd_iready", 32'(i_req_ready), 32'd1);
        check("rd_dready", 32'(d_req_ready), 32'd0);
        check("rd_ena", 32'(ena), 32'd1);
        check("rd_wea", 32'(wea), 32'd0);
        check("rd_addra", 32'(addra), 32'd1);
        tick;
        i_req_valid = 1'b0;
        mid;
        check("rd_ena_off", 32'(ena), 32'd0);
        check("rd_early_valid", 32'(i_rsp_valid), 32'd0);
        tick;
        mid;
        check("rd_ivalid", 32'(i_rsp_valid), 32'd1);
        check("rd_rdata", i_rsp_rdata, 32'hDEADBEEF);
        check("rd_err", 32'(i_rsp_err), 32'd0);
        check("rd_dvalid", 32'(d_rsp_valid), 32'd0);
        tick;
        // store then load
        d_req_valid = 1'b1;
        d_req_we = 1'b1;
        d_req_addr = 32'h8;
        d_req_wdata = 32'h11101010;
        mid;
        check("st_dready", 32'(d_req_ready), 32'd1);
        check("st_wea", 32'(wea), 32'd1);
        check("st_addra", 32'(addra), 32'd2);
        check("st_dina", dina, 32'h11101010);
        tick;
        d_req_valid = 1'b0;
        d_req_we = 1'b0;
        mid;
        check("st_dvalid", 32'(d_rsp_valid), 32'd1);
        check("st_err", 32'(d_rsp_err), 32'd0);
        check("st_wea_off", 32'(wea), 32'd0);
        check("st_dina_off", dina, 32'd0);
        tick;
        d_req_valid = 1'b1;
        mid;
        check("ld_ena", 32'(ena), 32'd1);
        check("ld_wea", 32'(wea), 32'd0);
        check("ld_addra", 32'(addra), 32'd2);
        tick;
        d_req_valid = 1'b0;
        tick;
        mid;
        check("ld_dvalid", 32'(d_rsp_valid), 32'd1);
        check("ld_rdata", d_rsp_rdata, 32'h11101010);
        tick;
        // address errors
        d_req_valid = 1'b1;
        d_req_addr = 32'h00040000;
        mid;
        check("derr_ready", 32'(d_req_ready), 32'd1);
        check("derr_ena", 32'(ena), 32'd0);
        tick;
        d_req_valid = 1'b0;
        mid;
        check("derr_valid", 32'(d_rsp_valid), 32'd1);
        check("derr_err", 32'(d_rsp_err), 32'd1);
        check("derr_rdata", d_rsp_rdata, 32'd0);
        check("derr_ena2", 32'(ena), 32'd0);
        tick;
        i_req_valid = 1'b1;
        i_req_addr = 32'h6;
        mid;
        check("ierr_ready", 32'(i_req_ready), 32'd1);
        check("ierr_ena", 32'(ena), 32'd0);
        tick;
        i_req_valid = 1'b0;
        mid;
        check("ierr_valid", 32'(i_rsp_valid), 32'd1);
        check("ierr_err", 32'(i_rsp_err), 32'd1);
        check("ierr_rdata", i_rsp_rdata, 32'd0);
        tick;
        // response backpressure on fetch with a pending data request
        i_req_valid = 1'b1;
        i_req_addr = 32'h4;
        i_rsp_ready = 1'b0;
        mid;
        check("bp_iready", 32'(i_req_ready), 32'd1);
        tick;
        i_req_valid = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr = 32'h8;
        mid;
        check("bp_wait_dready", 32'(d_req_ready), 32'd0);
        tick;
        for (int k = 0; k < 5; k++) begin
            mid;
            check("bp_hold_valid", 32'(i_rsp_valid), 32'd1);
            check("bp_hold_rdata", i_rsp_rdata, 32'hDEADBEEF);
            check("bp_hold_dready", 32'(d_req_ready), 32'd0);
            tick;
        end
        i_rsp_ready = 1'b1;
        mid;
        check("bp_hs_valid", 32'(i_rsp_valid), 32'd1);
        check("bp_hs_dready", 32'(d_req_ready), 32'd0);
        tick;
        mid;
        check("bp_dgrant", 32'(d_req_ready), 32'd1);
        check("bp_daddra", 32'(addra), 32'd2);
        tick;
        d_req_valid = 1'b0;
        tick;
        mid;
        check("bp_drdata", d_rsp_rdata, 32'h11101010);
        tick;
        // reset during RD_WAIT
        i_req_valid = 1'b1;
        i_req_addr = 32'h4;
        mid;
        check("mr_iready", 32'(i_req_ready), 32'd1);
        tick;
        d_req_valid = 1'b1;
        d_req_addr = 32'h0;
        #2;
        rsta_n = 1'b0;
        #1;
        check("mr_async_outs", 32'(any_out), 32'd0);
        tick;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        rsta_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid;
            check("mr_no_rsp", 32'(i_rsp_valid | d_rsp_valid), 32'd0);
            tick;
        end
        // contention from reset release
        rsta_n = 1'b0;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        tick;
        rsta_n = 1'b1;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            mid;
            check("ct_onehot", 32'(i_req_ready & d_req_ready), 32'd0);
            if (i_req_ready || d_req_ready) begin
                if (ng < 4) gseq[ng] = d_req_ready ? 1 : 2;
                ng++;
            end
            if (i_rsp_valid) check("ct_irdata", i_rsp_rdata, 32'hDEADBEEF);
            if (d_rsp_valid) check("ct_drdata", d_rsp_rdata, 32'h01234567);
            tick;
        end
        check("ct_grants", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) check("ct_order", 32'(gseq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
